uart_tx_dev: RTL

Memory-mapped UART transmitter that sits on a device port of `bus`, downstream of the address decoder, alongside `dpram`. The core writes bytes through the bus into an internal FIFO. A baud-rate counter and a frame FSM serialise them onto `txd_out` as 8N1 frames. Status, divisor and control registers are readable and writable through the same port.

---
 rtl/uart_tx_dev.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: bus-mapped 8N1 UART transmitter.
// TX FIFO, baud counter and frame FSM; TXDATA/STATUS/DIV/CTRL map.
module uart_tx_dev #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  req_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  we_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  txd_out,
  output logic                  irq_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  en_q, en_d;
  logic [15:0]           div_q, div_d;
  state_e                state_q, state_d;
  logic [15:0]           baud_q, baud_d;
  logic [15:0]           dact_q, dact_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            sh_q, sh_d;
  logic                  txd_q, txd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [1:0]  off;
  logic        wr, rd;
  logic        push_req, push_ok, pop;
  logic        div_wr, ctrl_wr;
  logic        full, empty, ovf_set;
  logic        load, bit_end, busy;
  logic [15:0] div_eff;
  logic        unused;

  assign unused = ^{addr_in[ADDR_WIDTH-1:4], addr_in[1:0],
                    wdata_in[DATA_WIDTH-1:16]};

  assign off      = addr_in[3:2];
  assign wr       = req_in & we_in;
  assign rd       = req_in & ~we_in;
  assign push_req = wr && (off == 2'd0);
  assign div_wr   = wr && (off == 2'd2);
  assign ctrl_wr  = wr && (off == 2'd3);

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  assign load    = en_q && !empty;
  assign bit_end = (baud_q == dact_q - 16'd1);
  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
  assign busy    = (state_q != IDLE) || !empty;

  assign txd_out   = txd_q;
  assign irq_out   = empty && (state_q == IDLE);
  assign rdata_out = rdata_q;

  // FIFO pointers/count and the software-visible registers.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop)     rptr_d = rptr_q + PW'(1);
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    div_d = div_wr ? wdata_in[15:0] : div_q;
    en_d  = ctrl_wr ? wdata_in[0] : en_q;
    ovf_d = ovf_q;
    if (ctrl_wr && wdata_in[1]) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  // Frame FSM: next state, baud/bit counters, shifter, pop and txd.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    dact_d  = dact_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (load) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
    end
    if (pop) begin
      sh_d   = mem_q[rptr_q];
      dact_d = div_eff;
      bit_d  = 3'd0;
      baud_d = 16'd0;
    end
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Read mux; holds the last value when no read is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      unique case (off)
        2'd1: begin
          rdata_d[0]    = busy;
          rdata_d[1]    = full;
          rdata_d[2]    = empty;
          rdata_d[3]    = ovf_q;
          rdata_d[15:8] = 8'(cnt_q);
        end
        2'd2:    rdata_d[15:0] = div_q;
        2'd3:    rdata_d[0]    = en_q;
        default: rdata_d = '0;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wptr_q] <= wdata_in[7:0];
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b1;
      div_q   <= DIV_RESET;
      state_q <= IDLE;
      baud_q  <= '0;
      dact_q  <= 16'd1;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      div_q   <= div_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      dact_q  <= dact_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
